pacman_mover: RTL and testbench
===============================

PACMAN_MOVER -- requirements
Module: pacman_mover

Interface
REQ-001 Parameter TICK_DIV, default 833_333: clock cycles per movement tick, which gives 60 moves/s at 50 MHz; legal range >= 2.
REQ-002 Parameter STEP, default 1: pixels moved per tick; legal range 1..8.
REQ-003 clk  input  1  the single system clock; all state SHALL be clocked on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 m_up, m_down, m_left, m_right  input  1 each  direction requests, synchronous to clk, level-sensitive.
REQ-006 e_start  input  1  game start request.
REQ-007 m_hold  input  1  pause request, level-sensitive.
REQ-008 xPacLoc  output  10  sprite centre column, registered.
REQ-009 yPacLoc  output  9  sprite centre row, registered.
REQ-010 moving  output  1  high when state = RUN and the latched direction is not NONE.
REQ-011 move_tick  output  1  single-cycle pulse on each movement tick.

Function
REQ-012 FSM states: IDLE, RUN, HOLD.
- IDLE to RUN when e_start = 1.
- RUN to HOLD when m_hold = 1.
- HOLD to RUN when m_hold = 0.
- e_start SHALL be ignored in RUN and HOLD.
REQ-013 Tick counter runs only in RUN:
- counts 0..TICK_DIV-1, wraps to 0;
- move_tick = 1 in the cycle the count equals TICK_DIV-1;
- frozen in HOLD; cleared on entry to RUN from IDLE.
REQ-014 Direction latch (NONE/UP/DOWN/LEFT/RIGHT) updates in RUN only.
- Priority when several requests are high: up > down > left > right.
- With no request, the latch SHALL keep its value (continuous motion).
REQ-015 On a move_tick cycle, position moves STEP pixels in the direction resolved that same cycle, so a new press coinciding with the tick takes effect on that tick.
- The updated value is visible on the cycle after move_tick.
- Up decreases y; left decreases x.
REQ-016 Bounds: X_MIN = 1, X_MAX = 638, Y_MIN = 1, Y_MAX = 478, so the 3x3 sprite stays on a 640x480 screen.
REQ-017 Non-wrap mode: a move that would leave the bounds SHALL saturate at the bound, and the latched direction SHALL clear to NONE on the same edge.
REQ-018 Arithmetic: compute in 11 bits before clamping so there is no unsigned underflow at the 0 edge.
REQ-019 Position SHALL not change in IDLE or HOLD, or in RUN cycles without move_tick.
REQ-020 Direction inputs SHALL be ignored in IDLE and HOLD.
REQ-021 m_hold and move_tick in the same RUN cycle: the move SHALL complete and the state SHALL go to HOLD on the same edge.

Reset
REQ-022 reset = 1 SHALL immediately force, without waiting for a clock edge:
- state = IDLE;
- xPacLoc = 320, yPacLoc = 240;
- direction = NONE, tick counter = 0;
- moving = 0, move_tick = 0.
REQ-023 Reset asserted mid-move SHALL discard any pending update; operation resumes from IDLE after deassertion.

Configuration
REQ-024 Macro PACMAN_WRAP_EN.
- Defined: crossing a bound SHALL wrap to the opposite bound (x > 638 to 1, x < 1 to 638, y > 478 to 1, y < 1 to 478), and the direction SHALL be retained.
- Undefined: saturate-and-stop behaviour per REQ-017.

Structure
REQ-025 Shared package pacman_pkg SHALL hold:
- screen constants H_ACTIVE = 640, V_ACTIVE = 480;
- bound constants X_MIN, X_MAX, Y_MIN, Y_MAX;
- start position constants X_START = 320, Y_START = 240;
- the direction enum and the FSM state enum.
REQ-026 One sub-module, pacman_tick_gen (parameter TICK_DIV; inputs enable and clear; output tick), SHALL implement the tick counter.

Verification
REQ-027 Bench scenarios (all with TICK_DIV = 4, STEP = 1):
- Reset, then e_start pulse, then m_right held 1 cycle: after 3 ticks xPacLoc = 323, yPacLoc = 240, moving = 1.
- m_up and m_left asserted together in RUN: next tick yPacLoc = 239, xPacLoc unchanged.
- Start at x = 637 moving right, non-wrap: next tick x = 638, then x stays 638 and moving = 0; with PACMAN_WRAP_EN the following tick gives x = 1.
- m_hold raised for 10 cycles mid-count: position and tick phase frozen; the first move_tick comes the remaining-count cycles after release; direction presses during HOLD have no effect.
- reset asserted asynchronously between clock edges during RUN: outputs read 320/240 with moving = 0 before the next edge; state is IDLE.
- e_start asserted while in RUN: no change to state, position or tick phase.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared constants, enums and helpers for the pacman movement block.
package pacman_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int X_MIN    = 1;
  localparam int X_MAX    = H_ACTIVE - 2;
  localparam int Y_MIN    = 1;
  localparam int Y_MAX    = V_ACTIVE - 2;
  localparam int X_START  = 320;
  localparam int Y_START  = 240;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD
  } state_t;

  // Fixed priority up > down > left > right; no request keeps the current heading.
  function automatic dir_t resolve_dir(input logic up, input logic down,
                                       input logic left, input logic right,
                                       input dir_t cur);
    if (up)         return DIR_UP;
    else if (down)  return DIR_DOWN;
    else if (left)  return DIR_LEFT;
    else if (right) return DIR_RIGHT;
    else            return cur;
  endfunction

endpackage

// File: rtl/pacman_mover_if.sv
// Control/position bundle between the game logic (master) and pacman_mover (slave).
interface pacman_mover_if;
  import pacman_pkg::*;

  // No valid/ready handshake: requests are level-sensitive and sampled every
  // rising clock edge; outputs are registered (move_tick is a one-cycle pulse).
  logic       m_up;
  logic       m_down;
  logic       m_left;
  logic       m_right;
  logic       e_start;
  logic       m_hold;
  logic [9:0] xPacLoc;
  logic [8:0] yPacLoc;
  logic       moving;
  logic       move_tick;
  state_t     dbg_state;

  modport master (
    output m_up, m_down, m_left, m_right, e_start, m_hold,
    input  xPacLoc, yPacLoc, moving, move_tick, dbg_state
  );

  modport slave (
    input  m_up, m_down, m_left, m_right, e_start, m_hold,
    output xPacLoc, yPacLoc, moving, move_tick, dbg_state
  );

endinterface

// File: rtl/pacman_tick_gen.sv
// Movement tick divider: counts 0..TICK_DIV-1 while enabled, pulses tick on the last count.
module pacman_tick_gen #(
  parameter int TICK_DIV = 833_333
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (enable)
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // Gated so a count frozen on LAST during a pause produces no tick.
  assign tick = enable && (count_q == LAST);

endmodule

// File: rtl/pacman_mover.sv
// Pacman sprite mover: IDLE/RUN/HOLD FSM, latched heading, bounded position.
// Optional macro PACMAN_WRAP_EN: wrap to the opposite bound instead of saturating.
module pacman_mover
  import pacman_pkg::*;
#(
  parameter int TICK_DIV = 833_333,
  parameter int STEP     = 1
) (
  input  logic           clk,
  input  logic           reset,
  pacman_mover_if.slave  bus
);

  localparam logic [10:0] STEP11 = 11'(STEP);

  state_t     state_q, state_d;
  dir_t       dir_q, dir_d, dir_res;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic [10:0] nx, ny;
  logic       tick;

  pacman_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (reset),
    .enable (state_q == ST_RUN),
    .clear  (state_q == ST_IDLE),
    .tick   (tick)
  );

  always_comb begin
    dir_res = resolve_dir(bus.m_up, bus.m_down, bus.m_left, bus.m_right, dir_q);
    nx = {1'b0, x_q};
    ny = {2'b00, y_q};
    // 11-bit arithmetic: a step below zero lands with bit 10 set.
    case (dir_res)
      DIR_UP:    ny = {2'b00, y_q} - STEP11;
      DIR_DOWN:  ny = {2'b00, y_q} + STEP11;
      DIR_LEFT:  nx = {1'b0, x_q} - STEP11;
      DIR_RIGHT: nx = {1'b0, x_q} + STEP11;
      default:   ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      ST_IDLE: if (bus.e_start) state_d = ST_RUN;
      ST_RUN: begin
        dir_d = dir_res;
        if (tick) begin
          if (nx[10] || nx < 11'(X_MIN)) begin
`ifdef PACMAN_WRAP_EN
            x_d = 10'(X_MAX);
`else
            x_d = 10'(X_MIN);  dir_d = DIR_NONE;
`endif
          end else if (nx > 11'(X_MAX)) begin
`ifdef PACMAN_WRAP_EN
            x_d = 10'(X_MIN);
`else
            x_d = 10'(X_MAX);  dir_d = DIR_NONE;
`endif
          end else begin
            x_d = nx[9:0];
          end
          if (ny[10] || ny < 11'(Y_MIN)) begin
`ifdef PACMAN_WRAP_EN
            y_d = 9'(Y_MAX);
`else
            y_d = 9'(Y_MIN);  dir_d = DIR_NONE;
`endif
          end else if (ny > 11'(Y_MAX)) begin
`ifdef PACMAN_WRAP_EN
            y_d = 9'(Y_MIN);
`else
            y_d = 9'(Y_MAX);  dir_d = DIR_NONE;
`endif
          end else begin
            y_d = ny[8:0];
          end
        end
        // A hold arriving with a tick still commits that tick's move.
        if (bus.m_hold) state_d = ST_HOLD;
      end
      ST_HOLD: if (!bus.m_hold) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_NONE;
      x_q     <= 10'(X_START);
      y_q     <= 9'(Y_START);
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign bus.xPacLoc   = x_q;
  assign bus.yPacLoc   = y_q;
  assign bus.moving    = (state_q == ST_RUN) && (dir_q != DIR_NONE);
  assign bus.move_tick = tick;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_pacman_mover.sv
// Directed bench for pacman_mover with TICK_DIV = 4, STEP = 1.
module tb_pacman_mover;
  import pacman_pkg::*;

  localparam int TICK_DIV = 4;

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  pacman_mover_if bus ();

  pacman_mover #(
    .TICK_DIV (TICK_DIV),
    .STEP     (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the cycle after the next move_tick, bounded.
  task automatic wait_tick(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 2 * TICK_DIV + 2; k++) begin
      if (bus.move_tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step(1);
    end
    if (seen) step(1);
    else begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: got no move_tick expected one within %0d cycles", tag, 2 * TICK_DIV + 2);
    end
  endtask

  initial begin
    bus.m_up = 0; bus.m_down = 0; bus.m_left = 0; bus.m_right = 0;
    bus.e_start = 0; bus.m_hold = 0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    check("rst_x", 32'(bus.xPacLoc), 320);
    check("rst_y", 32'(bus.yPacLoc), 240);
    check("rst_moving", 32'(bus.moving), 0);
    check("rst_tick", 32'(bus.move_tick), 0);
    check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    step(2);
    reset = 1'b0;

    // directions ignored in IDLE
    bus.m_right = 1; step(2); bus.m_right = 0;
    check("idle_x", 32'(bus.xPacLoc), 320);
    check("idle_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    check("idle_moving", 32'(bus.moving), 0);

    // start, then right for one cycle
    bus.e_start = 1; step(1); bus.e_start = 0;
    check("start_state", 32'(bus.dbg_state), 32'(ST_RUN));
    check("start_moving", 32'(bus.moving), 0);
    bus.m_right = 1; step(1); bus.m_right = 0;
    check("right_moving", 32'(bus.moving), 1);
    step(2);
    check("tick1_pulse", 32'(bus.move_tick), 1);
    step(1);
    check("tick1_x", 32'(bus.xPacLoc), 321);
    check("tick1_pulse_low", 32'(bus.move_tick), 0);
    step(8);
    check("tick3_x", 32'(bus.xPacLoc), 323);
    check("tick3_y", 32'(bus.yPacLoc), 240);
    check("tick3_moving", 32'(bus.moving), 1);

    // up + left together: up wins
    bus.m_up = 1; bus.m_left = 1; step(1); bus.m_up = 0; bus.m_left = 0;
    step(2);
    check("prio_pulse", 32'(bus.move_tick), 1);
    step(1);
    check("prio_y", 32'(bus.yPacLoc), 239);
    check("prio_x", 32'(bus.xPacLoc), 323);

    // e_start in RUN changes nothing
    bus.e_start = 1; step(1); bus.e_start = 0;
    check("estart_state", 32'(bus.dbg_state), 32'(ST_RUN));
    check("estart_y", 32'(bus.yPacLoc), 239);
    step(1);
    check("estart_phase_lo", 32'(bus.move_tick), 0);
    step(1);
    check("estart_phase_hi", 32'(bus.move_tick), 1);
    step(1);
    check("estart_y2", 32'(bus.yPacLoc), 238);

    // hold for 10 cycles mid-count, with a down press during hold
    step(1);
    bus.m_hold = 1; step(1);
    check("hold_state", 32'(bus.dbg_state), 32'(ST_HOLD));
    bus.m_down = 1;
    for (int i = 0; i < 9; i++) begin
      step(1);
      check("hold_tick", 32'(bus.move_tick), 0);
    end
    check("hold_y", 32'(bus.yPacLoc), 238);
    check("hold_moving", 32'(bus.moving), 0);
    bus.m_hold = 0; bus.m_down = 0;
    step(1);
    check("release_state", 32'(bus.dbg_state), 32'(ST_RUN));
    check("release_tick_lo", 32'(bus.move_tick), 0);
    step(1);
    check("release_tick_hi", 32'(bus.move_tick), 1);
    step(1);
    check("release_y", 32'(bus.yPacLoc), 237);

    // press coinciding with tick takes effect on that tick
    step(3);
    check("same_pulse", 32'(bus.move_tick), 1);
    bus.m_down = 1; step(1); bus.m_down = 0;
    check("same_y", 32'(bus.yPacLoc), 238);

    // hold arriving with a tick: move completes, state goes to HOLD
    step(3);
    check("holdtick_pulse", 32'(bus.move_tick), 1);
    bus.m_hold = 1; step(1);
    check("holdtick_y", 32'(bus.yPacLoc), 239);
    check("holdtick_state", 32'(bus.dbg_state), 32'(ST_HOLD));
    bus.m_hold = 0; step(1);
    step(3);
    check("holdtick_phase", 32'(bus.move_tick), 1);
    step(1);
    check("holdtick_y2", 32'(bus.yPacLoc), 240);

    // async reset between edges
    step(1);
    #3 reset = 1'b1;
    #1;
    check("areset_x", 32'(bus.xPacLoc), 320);
    check("areset_y", 32'(bus.yPacLoc), 240);
    check("areset_moving", 32'(bus.moving), 0);
    check("areset_tick", 32'(bus.move_tick), 0);
    check("areset_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    #2 reset = 1'b0;
    step(1);
    check("post_reset_state", 32'(bus.dbg_state), 32'(ST_IDLE));

    // right edge
    bus.e_start = 1; step(1); bus.e_start = 0;
    bus.m_right = 1; step(1); bus.m_right = 0;
    for (int i = 0; i < 317; i++) wait_tick("run_right");
    check("edge_x637", 32'(bus.xPacLoc), 637);
    wait_tick("edge_638");
    check("edge_x638", 32'(bus.xPacLoc), 638);
    check("edge_moving638", 32'(bus.moving), 1);
    wait_tick("edge_past");
`ifdef PACMAN_WRAP_EN
    check("wrap_x1", 32'(bus.xPacLoc), 1);
    check("wrap_moving", 32'(bus.moving), 1);
    bus.m_left = 1; step(1); bus.m_left = 0;
    wait_tick("wrap_left");
    check("wrap_left_x", 32'(bus.xPacLoc), 638);
    check("wrap_left_moving", 32'(bus.moving), 1);
`else
    check("sat_x638", 32'(bus.xPacLoc), 638);
    check("sat_moving", 32'(bus.moving), 0);
    wait_tick("sat_stay");
    check("sat_stay_x", 32'(bus.xPacLoc), 638);
    bus.m_left = 1; step(1); bus.m_left = 0;
    for (int i = 0; i < 637; i++) wait_tick("run_left");
    check("left_x1", 32'(bus.xPacLoc), 1);
    check("left_moving", 32'(bus.moving), 1);
    wait_tick("left_past");
    check("left_sat_x", 32'(bus.xPacLoc), 1);
    check("left_sat_moving", 32'(bus.moving), 0);
`endif

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
